// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - VGA mode timing constants and counter-width helper
package vga_timing_pkg;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
        logic        h_pol;
        logic        v_pol;
    } vga_mode_t;

    localparam vga_mode_t MODE_640X480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96,  h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,   v_bp: 33,
        h_pol: 1'b0, v_pol: 1'b0
    };

    localparam vga_mode_t MODE_800X600_60 = '{
        h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
        v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
        h_pol: 1'b1, v_pol: 1'b1
    };

    // Smallest width w with 2**w > max(h_total, v_total).
    function automatic int unsigned calc_width(input int unsigned h_total,
                                               input int unsigned v_total);
        int unsigned m;
        m = (h_total > v_total) ? h_total : v_total;
        return $clog2(m + 1);
    endfunction

    function automatic int unsigned mode_width(input vga_mode_t m);
        return calc_width(m.h_active + m.h_fp + m.h_sync + m.h_bp,
                          m.v_active + m.v_fp + m.v_sync + m.v_bp);
    endfunction

    localparam int unsigned MODE_640X480_WIDTH = mode_width(MODE_640X480_60);
    localparam int unsigned MODE_800X600_WIDTH = mode_width(MODE_800X600_60);

endpackage

// File: rtl/vga_pipe_delay.sv
// rtl/vga_pipe_delay.sv - fixed-depth register pipeline with asynchronous reset value
module vga_pipe_delay #(
    parameter int          W       = 1,
    parameter int          DEPTH   = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         pixel_clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= RST_VAL;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametric VGA timing generator with latency-matched fetch stream
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = MODE_640X480_60.h_active,
    parameter int unsigned H_FP     = MODE_640X480_60.h_fp,
    parameter int unsigned H_SYNC   = MODE_640X480_60.h_sync,
    parameter int unsigned H_BP     = MODE_640X480_60.h_bp,
    parameter int unsigned V_ACTIVE = MODE_640X480_60.v_active,
    parameter int unsigned V_FP     = MODE_640X480_60.v_fp,
    parameter int unsigned V_SYNC   = MODE_640X480_60.v_sync,
    parameter int unsigned V_BP     = MODE_640X480_60.v_bp,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned WIDTH    = 10
) (
    input  logic             pixel_clk,
    input  logic             rst,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] fetch_x,
    output logic [WIDTH-1:0] fetch_y,
    output logic             de,
    output logic [WIDTH-1:0] xpos,
    output logic [WIDTH-1:0] ypos,
    output logic             hsync,
    output logic             vsync,
    output logic             line_start,
    output logic             frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_read_lat
        $error("vga_timing_gen: READ_LAT must be within 1..4");
    end
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
        $error("vga_timing_gen: every timing parameter must be at least 1");
    end
    if (WIDTH < calc_width(H_TOTAL, V_TOTAL)) begin : g_bad_width
        $error("vga_timing_gen: WIDTH too small for H_TOTAL/V_TOTAL");
    end

    localparam logic [WIDTH-1:0] H_ACT      = WIDTH'(H_ACTIVE);
    localparam logic [WIDTH-1:0] H_SYNC_BEG = WIDTH'(H_ACTIVE + H_FP);
    localparam logic [WIDTH-1:0] H_SYNC_END = WIDTH'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [WIDTH-1:0] H_LAST     = WIDTH'(H_TOTAL - 1);
    localparam logic [WIDTH-1:0] V_ACT      = WIDTH'(V_ACTIVE);
    localparam logic [WIDTH-1:0] V_SYNC_BEG = WIDTH'(V_ACTIVE + V_FP);
    localparam logic [WIDTH-1:0] V_SYNC_END = WIDTH'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [WIDTH-1:0] V_LAST     = WIDTH'(V_TOTAL - 1);

    localparam int PW = 2 * WIDTH + 5;
    localparam logic [PW-1:0] PIPE_RST = {1'b0, {WIDTH{1'b0}}, {WIDTH{1'b0}},
                                          ~H_POL, ~V_POL, 2'b00};

    logic [WIDTH-1:0] h_cnt;
    logic [WIDTH-1:0] v_cnt;
    logic             raw_hsync;
    logic             raw_vsync;
    logic             raw_line_start;
    logic             raw_frame_start;
    logic [PW-1:0]    raw_bus;
    logic [PW-1:0]    disp_bus;

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + WIDTH'(1);
        end else begin
            h_cnt <= h_cnt + WIDTH'(1);
        end
    end

    // Fetch side is a pure decode of the counters; the display side is its delayed copy.
    always_comb begin
        fetch_valid     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        fetch_x         = fetch_valid ? h_cnt : '0;
        fetch_y         = fetch_valid ? v_cnt : '0;
        raw_hsync       = (h_cnt >= H_SYNC_BEG && h_cnt < H_SYNC_END) ? H_POL : ~H_POL;
        raw_vsync       = (v_cnt >= V_SYNC_BEG && v_cnt < V_SYNC_END) ? V_POL : ~V_POL;
        raw_line_start  = fetch_valid && (h_cnt == '0);
        raw_frame_start = raw_line_start && (v_cnt == '0);
        raw_bus         = {fetch_valid, fetch_x, fetch_y, raw_hsync, raw_vsync,
                           raw_line_start, raw_frame_start};
    end

    vga_pipe_delay #(
        .W       (PW),
        .DEPTH   (int'(READ_LAT)),
        .RST_VAL (PIPE_RST)
    ) u_disp_pipe (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .d         (raw_bus),
        .q         (disp_bus)
    );

    assign {de, xpos, ypos, hsync, vsync, line_start, frame_start} = disp_bus;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator that replaces the fixed 640x480 controller. It produces sync, display-enable and pixel coordinates from fully parametric horizontal and vertical timings, with selectable sync polarity. It also provides a fetch-side coordinate stream that leads the display outputs by a parametric read latency, so image memory with 1..4 cycles of latency can be used directly. It sits between the pixel clock domain and the image-memory/overlay path that drives the VGA DAC pins.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, horizontal sync width (cycles)
- H_BP, 48, horizontal back porch (cycles)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 1'b0, hsync active level
- V_POL, 1'b0, vsync active level
- READ_LAT, 1, memory read latency (legal 1..4); display outputs lag fetch outputs by this many cycles
- WIDTH, 10, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
- pixel_clk  in  1  pixel clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- fetch_valid  out  1  current counter position is inside the active area
- fetch_x, fetch_y  out  WIDTH  active-area coordinates for the memory read address
- de  out  1  display enable, aligned with returned pixel data
- xpos, ypos  out  WIDTH  coordinates of the pixel currently on screen
- hsync, vsync  out  1  sync outputs at the configured polarity
- line_start  out  1  one-cycle pulse on the first active pixel of each line (display side)
- frame_start  out  1  one-cycle pulse on pixel (0,0) of each frame (display side)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Line order is active, FP, sync, BP; frames use the same order.
- h_cnt runs 0..H_TOTAL-1 and wraps to 0. v_cnt increments only when h_cnt wraps, runs 0..V_TOTAL-1 and wraps to 0. Both are WIDTH-bit unsigned, and all comparisons are unsigned.
- Active region: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE. Inside it, fetch_x=h_cnt and fetch_y=v_cnt. Outside it, fetch_x and fetch_y hold 0 and fetch_valid=0.
- Raw hsync is active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC. Raw vsync uses the same rule on v_cnt and changes only at the h_cnt wrap.
- Raw line_start = fetch_valid && h_cnt==0. Raw frame_start = line_start && v_cnt==0.
- Fetch outputs are a combinational decode of the counter registers.
- The display outputs (de, xpos, ypos, hsync, vsync, line_start, frame_start) are the raw values passed through a READ_LAT-deep register pipeline. Every display output is a flop output, so the outputs are glitch-free.
- Reset values: counters 0; every pipeline stage holds de=0, xpos=ypos=0, line_start=frame_start=0, hsync=~H_POL, vsync=~V_POL. fetch_* decode from counters (0,0), so fetch_valid=1 with coordinates 0,0 while rst is high.
- Reset asserted mid-frame: all registers clear immediately. After release, counting restarts at (0,0) and no partial frame is completed.

## Timing
- Cycle 0 is the first pixel_clk edge-to-edge cycle after rst falls. In cycle 0 the counters are (0,0) and fetch_valid=1.
- In cycle READ_LAT: de=1, xpos=ypos=0, frame_start=1, line_start=1.
- Memory contract: an address presented on fetch_x/fetch_y in cycle t returns data in cycle t+READ_LAT. That data is valid wherever de=1.
- hsync period is H_TOTAL cycles and its active width is H_SYNC. vsync active width is V_SYNC*H_TOTAL cycles. frame_start period is H_TOTAL*V_TOTAL cycles.
- The edges of hsync and vsync are delayed by the same READ_LAT as de, so relative sync/DE timing is independent of READ_LAT.

## Structure
- Package vga_timing_pkg holds the timing constants for the 640x480@60 and 800x600@60 modes and a function that computes the counter width for a given mode.
- One sub-module, vga_pipe_delay: a parametrised-width, parametrised-depth register pipeline with an asynchronous reset value, instantiated once for the bundled display signals.
- Elaboration-time checks: READ_LAT is in 1..4, every timing parameter is >=1, and 2**WIDTH > max(H_TOTAL, V_TOTAL).

## Test plan
- Reset held, then released with defaults: hsync=vsync=1 and de=0 during reset. In cycle 1, de=1, xpos=ypos=0 and frame_start=1.
- Defaults, one full frame: hsync is low for 96 of every 800 cycles; de is high for 640 cycles per line on exactly 480 lines; vsync is low for 1600 cycles; the next frame_start comes 420000 cycles later.
- READ_LAT=3 with a model RAM returning (x+y*640) after 3 cycles: on every cycle with de=1, data == xpos+ypos*640.
- Tiny mode H=4/1/1/1, V=3/1/1/1, H_POL=V_POL=1: xpos wraps 3->0 and the v counter wraps after 6 lines; hsync is high for 1 of every 7 cycles.
- rst pulsed mid-line at h_cnt=300, v_cnt=200: outputs return to reset values asynchronously, and frame_start appears READ_LAT cycles after release.
- Line boundary check: line_start pulses exactly 480 times between consecutive frame_start pulses, and never while de=0.
